// File: rtl/cordic_rotation_engine.sv
// Iterative CORDIC rotation: cos/sin of a Q16.16 angle, one micro-rotation per cycle.
// Latency: ITER cycles from input handshake to out_valid; one operation in flight at a time.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready.
// Optional input angle clamp to +/-pi/2 under CORDIC_ANGLE_CLAMP_EN.
module cordic_rotation_engine #(
    parameter int ITER = 16,
    parameter int W    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  angle_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  cos_out,
    output logic [W-1:0]  sin_out,
    output logic [31:0]   lut_idx,
    input  logic [31:0]   lut_data
);

    // Pre-scaling by the CORDIC gain K = 0.607253 lets the rotation end at unit magnitude.
    localparam logic signed [W-1:0] K_INIT = W'(39797);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t              state, state_nxt;
    logic signed [W-1:0] x, y, z;
    logic signed [W-1:0] x_nxt, y_nxt, z_nxt;
    logic signed [W-1:0] x_sh, y_sh, atan_w, z_load;
    logic [4:0]          cnt, cnt_nxt;
    logic [W-1:0]        cos_r, sin_r, cos_nxt, sin_nxt;

`ifdef CORDIC_ANGLE_CLAMP_EN
    localparam logic signed [W-1:0] HALF_PI = W'(102944);

    always_comb begin
        z_load = $signed(angle_in);
        if ($signed(angle_in) > HALF_PI) begin
            z_load = HALF_PI;
        end else if ($signed(angle_in) < -HALF_PI) begin
            z_load = -HALF_PI;
        end
    end
`else
    assign z_load = $signed(angle_in);
`endif

    assign atan_w  = W'(lut_data);
    assign x_sh    = x >>> cnt;
    assign y_sh    = y >>> cnt;
    assign cos_out = cos_r;
    assign sin_out = sin_r;

    always_comb begin
        state_nxt = state;
        x_nxt     = x;
        y_nxt     = y;
        z_nxt     = z;
        cnt_nxt   = cnt;
        cos_nxt   = cos_r;
        sin_nxt   = sin_r;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        lut_idx   = '0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    x_nxt     = K_INIT;
                    y_nxt     = '0;
                    z_nxt     = z_load;
                    cnt_nxt   = '0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                lut_idx = 32'(cnt);
                // Rotate toward z = 0; the table returns atan(2^-cnt) this same cycle.
                if (!z[W-1]) begin
                    x_nxt = x - y_sh;
                    y_nxt = y + x_sh;
                    z_nxt = z - atan_w;
                end else begin
                    x_nxt = x + y_sh;
                    y_nxt = y - x_sh;
                    z_nxt = z + atan_w;
                end
                cnt_nxt = cnt + 5'd1;
                if (cnt == 5'(ITER - 1)) begin
                    state_nxt = DONE;
                    cos_nxt   = x_nxt;
                    sin_nxt   = y_nxt;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            x     <= '0;
            y     <= '0;
            z     <= '0;
            cnt   <= '0;
            cos_r <= '0;
            sin_r <= '0;
        end else begin
            state <= state_nxt;
            x     <= x_nxt;
            y     <= y_nxt;
            z     <= z_nxt;
            cnt   <= cnt_nxt;
            cos_r <= cos_nxt;
            sin_r <= sin_nxt;
        end
    end

endmodule

// File: tb/tb_cordic_rotation_engine.sv
// Directed bench for cordic_rotation_engine with a combinational atan(2^-i) table.
module tb_cordic_rotation_engine;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] angle_in;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] cos_out;
    logic signed [31:0] sin_out;
    logic [31:0]        lut_idx;
    logic [31:0]        lut_data;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int acc_q[$];
    logic signed [31:0] cos_q[$];
    logic signed [31:0] sin_q[$];

    always #5 clk = ~clk;

    cordic_rotation_engine #(.ITER(16), .W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .angle_in  (angle_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cos_out   (cos_out),
        .sin_out   (sin_out),
        .lut_idx   (lut_idx),
        .lut_data  (lut_data)
    );

    // round(atan(2^-i) * 65536)
    always_comb begin
        case (lut_idx)
            32'd0:   lut_data = 32'd51472;
            32'd1:   lut_data = 32'd30386;
            32'd2:   lut_data = 32'd16055;
            32'd3:   lut_data = 32'd8150;
            32'd4:   lut_data = 32'd4091;
            32'd5:   lut_data = 32'd2047;
            32'd6:   lut_data = 32'd1024;
            32'd7:   lut_data = 32'd512;
            32'd8:   lut_data = 32'd256;
            32'd9:   lut_data = 32'd128;
            32'd10:  lut_data = 32'd64;
            32'd11:  lut_data = 32'd32;
            32'd12:  lut_data = 32'd16;
            32'd13:  lut_data = 32'd8;
            32'd14:  lut_data = 32'd4;
            32'd15:  lut_data = 32'd2;
            default: lut_data = 32'd0;
        endcase
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (in_valid && in_ready) acc_q.push_back(cyc);
        if (out_valid && out_ready) begin
            cos_q.push_back(cos_out);
            sin_q.push_back(sin_out);
        end
    end

    task automatic chk(input string tag, input longint got, input longint exp, input longint tol = 0);
        n_vec++;
        if (got > exp + tol || got < exp - tol) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [31:0] a);
        int guard = 0;
        in_valid = 1'b1;
        angle_in = a;
        while (!in_ready && guard < 100) begin
            tick();
            guard++;
        end
        chk("accept_wait_bound", guard < 100, 1);
        tick();
        in_valid = 1'b0;
        chk("in_ready_drop", in_ready, 0);
    endtask

    task automatic do_op(input logic signed [31:0] a, input bit lut_chk,
                         output logic signed [31:0] c, output logic signed [31:0] s, output int lat);
        send(a);
        lat = 0;
        while (!out_valid && lat < 100) begin
            if (lut_chk) chk($sformatf("lut_idx_step%0d", lat), lut_idx, lat);
            tick();
            lat++;
        end
        c = cos_out;
        s = sin_out;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic signed [31:0] c, s, c_hold, s_hold, c_ref, s_ref;
        int lat, seen, guard;
        logic signed [31:0] ang6[4];
        int exp_c6[4];
        int exp_s6[4];

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; angle_in = '0;
        tick();
        tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_cos", cos_out, 0);
        chk("rst_sin", sin_out, 0);
        chk("rst_lut_idx", lut_idx, 0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", in_ready, 1);

        // Test 1: zero angle, latency and table stepping
        do_op(32'sd0, 1'b1, c, s, lat);
        chk("t1_latency", lat, 16);
        chk("t1_cos", c, 65536, 8);
        chk("t1_sin", s, 0, 8);
        chk("t1_in_ready_idle", in_ready, 1);
        chk("t1_cos_hold_idle", cos_out, c);

        // Test 2: pi/4 and -pi/2
        do_op(32'sd51471, 1'b0, c, s, lat);
        chk("t2a_latency", lat, 16);
        chk("t2a_cos", c, 46341, 8);
        chk("t2a_sin", s, 46341, 8);
        do_op(-32'sd102944, 1'b0, c, s, lat);
        chk("t2b_cos", c, 0, 8);
        chk("t2b_sin", s, -65536, 8);

        // Test 3: result backpressure with a stray input request
        send(32'sd34315);
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk("t3_latency", lat, 16);
        c_hold = cos_out;
        s_hold = sin_out;
        chk("t3_cos", c_hold, 56756, 8);
        chk("t3_sin", s_hold, 32768, 8);
        in_valid = 1'b1;
        angle_in = 32'sd0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_hold_valid", out_valid, 1);
            chk("t3_hold_cos", cos_out, c_hold);
            chk("t3_hold_sin", sin_out, s_hold);
            chk("t3_in_ready_low", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t3_in_ready_after", in_ready, 1);
        chk("t3_out_valid_drop", out_valid, 0);
        tick();
        tick();
        chk("t3_not_queued", in_ready, 1);
        chk("t3_cos_hold_idle", cos_out, c_hold);

        // Test 4: reset in the middle of a rotation
        send(32'sd51471);
        guard = 0;
        while (lut_idx != 32'd7 && guard < 50) begin
            tick();
            guard++;
        end
        chk("t4_reach_idx7", lut_idx, 7);
        rst = 1'b1;
        #1;
        chk("t4_in_ready_in_rst", in_ready, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("t4_out_valid", out_valid, 0);
        chk("t4_cos", cos_out, 0);
        chk("t4_sin", sin_out, 0);
        chk("t4_lut_idx", lut_idx, 0);
        chk("t4_in_ready", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("t4_no_out_valid", seen, 0);

        // Test 5: angle beyond the convergence range
        do_op(32'sd200000, 1'b0, c, s, lat);
        chk("t5_latency", lat, 16);
        chk("t5_in_ready_after", in_ready, 1);
`ifdef CORDIC_ANGLE_CLAMP_EN
        do_op(32'sd102944, 1'b0, c_ref, s_ref, lat);
        chk("t5_clamp_cos", c, c_ref);
        chk("t5_clamp_sin", s, s_ref);
        chk("t5_ref_cos", c_ref, 0, 8);
        chk("t5_ref_sin", s_ref, 65536, 8);
`endif

        // Test 6: back-to-back with out_ready tied high
        ang6[0] = 32'sd0;      exp_c6[0] = 65536; exp_s6[0] = 0;
        ang6[1] = 32'sd51471;  exp_c6[1] = 46341; exp_s6[1] = 46341;
        ang6[2] = -32'sd51471; exp_c6[2] = 46341; exp_s6[2] = -46341;
        ang6[3] = 32'sd34315;  exp_c6[3] = 56756; exp_s6[3] = 32768;
        acc_q.delete();
        cos_q.delete();
        sin_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(ang6[i]);
        guard = 0;
        while (cos_q.size() < 4 && guard < 100) begin
            tick();
            guard++;
        end
        out_ready = 1'b0;
        chk("t6_results", cos_q.size(), 4);
        chk("t6_accepts", acc_q.size(), 4);
        if (acc_q.size() == 4) begin
            for (int i = 1; i < 4; i++)
                chk($sformatf("t6_spacing%0d", i), acc_q[i] - acc_q[i-1], 18);
        end
        if (cos_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("t6_cos%0d", i), cos_q[i], exp_c6[i], 8);
                chk($sformatf("t6_sin%0d", i), sin_q[i], exp_s6[i], 8);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
